// File: rtl/irrigation_tank_ctrl_pkg.sv
// Shared encodings for the tank sequencer: FSM states, level codes and the
// probe patterns that map onto them (also used by the level-display decoder).
package irrigation_tank_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_IRR   = 2'd2;
   localparam logic [1:0] ST_FAULT = 2'd3;

   localparam logic [1:0] LVL_EMPTY = 2'd0;
   localparam logic [1:0] LVL_LOW   = 2'd1;
   localparam logic [1:0] LVL_MID   = 2'd2;
   localparam logic [1:0] LVL_HIGH  = 2'd3;

   // probe pattern order is {A (high), M (mid), B (low)}
   localparam logic [2:0] PAT_EMPTY = 3'b000;
   localparam logic [2:0] PAT_LOW   = 3'b001;
   localparam logic [2:0] PAT_MID   = 3'b011;
   localparam logic [2:0] PAT_HIGH  = 3'b111;

   function automatic logic pat_valid(input logic [2:0] pat);
      return (pat == PAT_EMPTY) || (pat == PAT_LOW) ||
             (pat == PAT_MID)   || (pat == PAT_HIGH);
   endfunction

   function automatic logic [1:0] pat_level(input logic [2:0] pat);
      logic [1:0] lvl;
      case (pat)
         PAT_LOW:  lvl = LVL_LOW;
         PAT_MID:  lvl = LVL_MID;
         PAT_HIGH: lvl = LVL_HIGH;
         default:  lvl = LVL_EMPTY;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/irrigation_tank_ctrl_level_debouncer.sv
// Probe front end: two-flop synchroniser, stability counter and code map.
// A code is accepted once, on the DEB_LEN-th consecutive equal sample.
module level_debouncer
   import irrigation_tank_ctrl_pkg::*;
#(
   parameter int DEB_LEN = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] probes,
   output logic [1:0] lvl_code,
   output logic       lvl_valid,
   output logic       inv_lvl,
   output logic       code_ok
);

   localparam int DW = $clog2(DEB_LEN + 1);

   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    smp;
   logic [1:0]    sync_vld;
   logic [DW-1:0] stab_cnt;
   logic          accept;

   // samples taken before the synchroniser has filled are ignored
   assign accept = sync_vld[1] && (sync2 == smp) && (stab_cnt == DW'(DEB_LEN - 1));

   // synchronise the raw probes and track synchroniser fill after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= '0;
         sync2    <= '0;
         sync_vld <= '0;
      end else begin
         sync1    <= probes;
         sync2    <= sync1;
         sync_vld <= {sync_vld[0], 1'b1};
      end
   end

   // count consecutive equal samples; saturating at DEB_LEN prevents re-acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp      <= '0;
         stab_cnt <= '0;
      end else if (sync_vld[1]) begin
         if ((stab_cnt == '0) || (sync2 != smp)) begin
            smp      <= sync2;
            stab_cnt <= DW'(1);
         end else if (stab_cnt != DW'(DEB_LEN)) begin
            stab_cnt <= stab_cnt + DW'(1);
         end
      end
   end

   // map accepted codes; an invalid code keeps the old level and pulses inv_lvl
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_code  <= LVL_EMPTY;
         lvl_valid <= 1'b0;
         inv_lvl   <= 1'b0;
         code_ok   <= 1'b0;
      end else begin
         inv_lvl <= 1'b0;
         if (accept) begin
            if (pat_valid(sync2)) begin
               lvl_code  <= pat_level(sync2);
               lvl_valid <= 1'b1;
               code_ok   <= 1'b1;
            end else begin
               inv_lvl   <= 1'b1;
               code_ok   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/irrigation_tank_ctrl.sv
// Tank fill / irrigation sequencer with pump-timeout and invalid-probe fault.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_IDLE  | pump and valve off, waiting for a valid level
//  ST_FILL  | pump on until level high; timeout -> fault
//  ST_IRR   | valve open for IRR_TIME ticks, or until dry / request dropped
//  ST_FAULT | everything off until fault_clr with a valid probe code
module irrigation_tank_ctrl
   import irrigation_tank_ctrl_pkg::*;
#(
   parameter int DEB_LEN      = 16,
   parameter int FILL_TIMEOUT = 120,
   parameter int IRR_TIME     = 30,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       probe_a,
   input  logic       probe_m,
   input  logic       probe_b,
   input  logic       irr_req,
   input  logic       fault_clr,
   output logic       pump,
   output logic       valve,
   output logic       alarm,
   output logic [1:0] lvl_code,
   output logic       lvl_valid,
   output logic [1:0] state_o
);

   logic [1:0]       state;
   logic [1:0]       nxt;
   logic [CNT_W-1:0] tick_cnt;
   logic             inv_lvl;
   logic             code_ok;

   level_debouncer #(.DEB_LEN(DEB_LEN)) u_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .probes    ({probe_a, probe_m, probe_b}),
      .lvl_code  (lvl_code),
      .lvl_valid (lvl_valid),
      .inv_lvl   (inv_lvl),
      .code_ok   (code_ok)
   );

   assign state_o = state;

   // next-state decode; an invalid probe code overrides everything
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: begin
            if (lvl_valid) begin
               if (lvl_code <= LVL_LOW) nxt = ST_FILL;
               else if (irr_req)        nxt = ST_IRR;
            end
         end
         ST_FILL: begin
            if (lvl_code == LVL_HIGH)                   nxt = ST_IDLE;
            else if (tick_cnt == CNT_W'(FILL_TIMEOUT)) nxt = ST_FAULT;
         end
         ST_IRR: begin
            if ((tick_cnt == CNT_W'(IRR_TIME)) || (lvl_code <= LVL_LOW) || !irr_req)
               nxt = ST_IDLE;
         end
         default: begin
            if (fault_clr && code_ok) nxt = ST_IDLE;
         end
      endcase
      if (inv_lvl) nxt = ST_FAULT;
   end

   // tick counter: cleared on state entry, saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           tick_cnt <= '0;
      else if (nxt != state)                tick_cnt <= '0;
      else if (tick && (tick_cnt != '1))    tick_cnt <= tick_cnt + CNT_W'(1);
   end

   // state and registered Moore outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         pump  <= 1'b0;
         valve <= 1'b0;
         alarm <= 1'b0;
      end else begin
         state <= nxt;
         pump  <= (nxt == ST_FILL);
         valve <= (nxt == ST_IRR);
         alarm <= (state == ST_FAULT) || (lvl_valid && (lvl_code == LVL_EMPTY));
      end
   end

endmodule

// File: tb/tb_irrigation_tank_ctrl.sv
// Bench for irrigation_tank_ctrl: directed scenarios plus a random soak,
// all checked every cycle against a behavioural model.
module tb_irrigation_tank_ctrl;

   localparam int DEB_LEN      = 4;
   localparam int FILL_TIMEOUT = 5;
   localparam int IRR_TIME     = 3;
   localparam int CNT_W        = 8;
   localparam int CNT_MAX      = (1 << CNT_W) - 1;

   localparam int S_IDLE = 0, S_FILL = 1, S_IRR = 2, S_FAULT = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       probe_a = 1'b0, probe_m = 1'b0, probe_b = 1'b0;
   logic       irr_req = 1'b0;
   logic       fault_clr = 1'b0;
   logic       pump, valve, alarm, lvl_valid;
   logic [1:0] lvl_code, state_o;

   irrigation_tank_ctrl #(
      .DEB_LEN(DEB_LEN), .FILL_TIMEOUT(FILL_TIMEOUT),
      .IRR_TIME(IRR_TIME), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick),
      .probe_a(probe_a), .probe_m(probe_m), .probe_b(probe_b),
      .irr_req(irr_req), .fault_clr(fault_clr),
      .pump(pump), .valve(valve), .alarm(alarm),
      .lvl_code(lvl_code), .lvl_valid(lvl_valid), .state_o(state_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   int samp[$];
   int m_code, m_valid, m_ok, m_inv, m_state, m_cnt, m_pump, m_valve, m_alarm;

   function automatic void model_reset();
      samp.delete();
      m_code = 0; m_valid = 0; m_ok = 0; m_inv = 0;
      m_state = S_IDLE; m_cnt = 0; m_pump = 0; m_valve = 0; m_alarm = 0;
   endfunction

   function automatic int pat_to_level(input int p);
      case (p)
         0: return 0;
         1: return 1;
         3: return 2;
         7: return 3;
         default: return -1;
      endcase
   endfunction

   function automatic void model_edge();
      int nx, idx, run, lv;
      nx = m_state;
      case (m_state)
         S_IDLE:  if (m_valid != 0) begin
                     if (m_code <= 1) nx = S_FILL;
                     else if (irr_req) nx = S_IRR;
                  end
         S_FILL:  if (m_code == 3) nx = S_IDLE;
                  else if (m_cnt == FILL_TIMEOUT) nx = S_FAULT;
         S_IRR:   if (m_cnt == IRR_TIME || m_code <= 1 || !irr_req) nx = S_IDLE;
         default: if (fault_clr && m_ok != 0) nx = S_IDLE;
      endcase
      if (m_inv != 0) nx = S_FAULT;
      m_alarm = (m_state == S_FAULT || (m_valid != 0 && m_code == 0)) ? 1 : 0;
      if (nx != m_state) m_cnt = 0;
      else if (tick && m_cnt < CNT_MAX) m_cnt++;
      m_state = nx;
      m_pump  = (nx == S_FILL) ? 1 : 0;
      m_valve = (nx == S_IRR) ? 1 : 0;

      // a sample reaches the decision two clocks after it is taken; it is
      // accepted when it completes a run of exactly DEB_LEN equal samples
      samp.push_back(int'({probe_a, probe_m, probe_b}));
      m_inv = 0;
      if (samp.size() >= 3) begin
         idx = samp.size() - 3;
         run = 0;
         for (int j = idx; j >= 0 && run <= DEB_LEN && samp[j] == samp[idx]; j--) run++;
         if (run == DEB_LEN) begin
            lv = pat_to_level(samp[idx]);
            if (lv >= 0) begin
               m_code = lv; m_valid = 1; m_ok = 1;
            end else begin
               m_inv = 1; m_ok = 0;
            end
         end
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic compare_all();
      check("state", state_o, m_state);
      check("pump", pump, m_pump);
      check("valve", valve, m_valve);
      check("alarm", alarm, m_alarm);
      check("lvl_code", lvl_code, m_code);
      check("lvl_valid", lvl_valid, m_valid);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
      cyc++;
      tick = ((cyc % 10) == 0);
   endtask

   task automatic set_probes(input int p);
      logic [2:0] v;
      v = p[2:0];
      {probe_a, probe_m, probe_b} = v;
   endtask

   task automatic hold(input int p, input int n);
      set_probes(p);
      repeat (n) step();
   endtask

   task automatic pulse_clr();
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int pats[4] = '{0, 1, 3, 7};

   initial begin
      int found, p, len;
      model_reset();
      #1;

      // 1: reset with empty tank, debounce latency, FILL entry
      set_probes(0);
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         step();
         if (i == 5) check("deb_lat_pre", lvl_valid, 0);
         if (i == 6) check("deb_lat", lvl_valid, 1);
      end
      step();
      check("fill_entry_state", state_o, S_FILL);
      check("fill_entry_pump", pump, 1);
      check("fill_entry_alarm", alarm, 1);

      // 2: fill to high
      hold(1, 8);
      hold(3, 8);
      hold(7, 8);
      check("fill_done_state", state_o, S_IDLE);
      check("fill_done_pump", pump, 0);

      // 3: fill timeout then clear with mid level
      hold(1, 70);
      check("timeout_state", state_o, S_FAULT);
      check("timeout_alarm", alarm, 1);
      hold(3, 8);
      pulse_clr();
      hold(3, 4);
      check("clr_state", state_o, S_IDLE);

      // 4: irrigation, then dry protection mid-cycle
      hold(7, 8);
      irr_req = 1'b1;
      hold(7, 45);
      irr_req = 1'b0;
      hold(7, 5);
      irr_req = 1'b1;
      hold(7, 12);
      hold(1, 8);
      irr_req = 1'b0;
      check("dry_valve", valve, 0);
      hold(7, 12);

      // 5: invalid code with fault_clr coincident with inv_lvl
      set_probes(5);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         step();
         if (m_inv != 0) found = 1;
      end
      check("inv_seen", found, 1);
      pulse_clr();
      check("inv_clr_stay", state_o, S_FAULT);
      hold(5, 3);
      pulse_clr();
      check("inv_code_stay", state_o, S_FAULT);
      hold(7, 8);
      pulse_clr();
      hold(7, 3);
      // glitch shorter than the debounce window
      hold(3, 3);
      for (int i = 0; i < 10; i++) begin
         hold(7, 1);
         check("glitch_code", lvl_code, 3);
      end

      // 6: asynchronous reset in the middle of irrigation
      irr_req = 1'b1;
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         hold(7, 1);
         if (m_state == S_IRR) found = 1;
      end
      check("irr_reached", found, 1);
      check("irr_valve", valve, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valve", valve, 0);
      check("arst_state", state_o, 0);
      check("arst_pump", pump, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;
      irr_req = 1'b0;

      // 7: random soak
      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 9) < 8) p = pats[$urandom_range(0, 3)];
         else p = int'($urandom_range(0, 7));
         len = int'($urandom_range(1, 25));
         if ($urandom_range(0, 9) < 3) irr_req = ~irr_req;
         set_probes(p);
         if ($urandom_range(0, 9) < 3) pulse_clr();
         repeat (len) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
